// File: rtl/muldiv4_seq_pkg.sv
// Shared types and constants for the muldiv4_seq sequencer.
// State and op encodings, iteration count.
package muldiv4_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

  localparam int ITERS = 4;
  localparam logic [1:0] LAST_ITER = 2'(ITERS - 1);

endpackage

// File: rtl/muldiv4_seq_addsub.sv
// 4-bit ripple adder/subtractor shared by MUL and DIV.
// Ctrl=1 subtracts; carry-in is tied to Ctrl.
module AddSub4b (
  input  logic       Ctrl,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] S,
  output logic       Co
);

  logic [4:0] c;
  logic [3:0] bx;

  // ripple chain of full adders over A and conditionally inverted B
  always_comb begin
    bx   = B ^ {4{Ctrl}};
    c    = '0;
    S    = '0;
    c[0] = Ctrl;
    for (int i = 0; i < 4; i++) begin
      S[i]     = A[i] ^ bx[i] ^ c[i];
      c[i + 1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
    end
    Co = c[4];
  end

endmodule

// File: rtl/muldiv4_seq.sv
// Multi-cycle 4-bit unsigned multiply / divide sequencer.
// Shift-add MUL and restoring DIV over one shared adder.
import muldiv4_seq_pkg::*;

module muldiv4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       dz
);

  state_t     state;
  state_t     state_nx;
  op_t        op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] hi;
  logic [3:0] lo;
  logic [1:0] cnt;

  logic       add_ctrl;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] sum;
  logic       co;
  logic [4:0] sh;
  logic       take;
  logic [3:0] hi_nx;
  logic [3:0] lo_nx;

  AddSub4b u_addsub (
    .Ctrl (add_ctrl),
    .A    (add_a),
    .B    (add_b),
    .S    (sum),
    .Co   (co)
  );

  // operand muxing into the shared adder and next hi/lo
  always_comb begin
    sh       = {hi, lo[3]};
    add_ctrl = 1'b0;
    add_a    = hi;
    add_b    = lo[0] ? a_q : 4'h0;
    take     = 1'b0;
    hi_nx    = hi;
    lo_nx    = lo;
    if (op_q == OP_DIV) begin
      add_ctrl = 1'b1;
      add_a    = sh[3:0];
      add_b    = b_q;
      take     = sh[4] | co;
      hi_nx    = take ? sum : sh[3:0];
      lo_nx    = {lo[2:0], take};
    end else begin
      {hi_nx, lo_nx} = {co, sum, lo[3:1]};
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST_ITER) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand capture, iterations, result and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      dz     <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op_t'(op);
            a_q  <= a;
            b_q  <= b;
            hi   <= '0;
            lo   <= op ? a : b;
            dz   <= op && (b == 4'h0);
            cnt  <= '0;
          end
        end
        RUN: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + 2'd1;
          if (cnt == LAST_ITER) begin
            result <= dz ? {a_q, 4'hF}
                         : {hi_nx, lo_nx};
          end
        end
        DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv4_seq.sv
// Self-checking bench for muldiv4_seq.
// Directed table, corner sequences, random vs. model.
module tb_muldiv4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       dz;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic       dz;
  } vec_t;

  muldiv4_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .dz     (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // reference: plain arithmetic, dz in bit 8
  function automatic logic [8:0] model(input logic o,
                                       input logic [3:0] x,
                                       input logic [3:0] y);
    int xi;
    int yi;
    xi = int'(x);
    yi = int'(y);
    if (!o) return {1'b0, 8'(xi * yi)};
    if (yi == 0) return {1'b1, x, 4'hF};
    return {1'b0, 4'(xi % yi), 4'(xi / yi)};
  endfunction

  // one request; checks latency, busy, pulse width, result
  task automatic do_op(input logic o,
                       input logic [3:0] x,
                       input logic [3:0] y,
                       input bit noisy,
                       input logic [7:0] exp_r,
                       input logic exp_d);
    int lat;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    op    = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      check("busy_in_flight", 32'(busy), 32'd1);
      if (noisy) begin
        start = 1'b1;
        a     = 4'($urandom);
        b     = 4'($urandom);
        op    = 1'($urandom);
      end
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'd5);
    check("result", 32'(result), 32'(exp_r));
    check("dz", 32'(dz), 32'(exp_d));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
    check("result_hold", 32'(result), 32'(exp_r));
  endtask

  vec_t vecs[$];
  logic [8:0] m;
  bit seen;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = 4'h0;
    b     = 4'h0;

    vecs.push_back('{1'b0, 4'hD, 4'hB, 8'h8F, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 8'hE1, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'h9, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 4'hD, 4'h3, 8'h14, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 4'h1, 8'h0F, 1'b0});
    vecs.push_back('{1'b1, 4'h2, 4'h7, 8'h20, 1'b0});
    vecs.push_back('{1'b1, 4'h9, 4'h0, 8'h9F, 1'b1});
    vecs.push_back('{1'b0, 4'h2, 4'h3, 8'h06, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
            vecs[i].res, vecs[i].dz);

    // start held high during RUN/DONE must be ignored
    do_op(1'b1, 4'hE, 4'h4, 1'b1, 8'h23, 1'b0);
    do_op(1'b0, 4'h7, 4'h6, 1'b1, 8'h2A, 1'b0);

    // reset in iteration 2 aborts silently
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 4'h7;
    b     = 4'h5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dz", 32'(dz), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    do_op(1'b0, 4'h9, 4'h7, 1'b0, 8'h3F, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic       ro;
      logic [3:0] ra;
      logic [3:0] rb;
      ro = 1'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom_range(0, 15));
      m  = model(ro, ra, rb);
      do_op(ro, ra, rb, (i % 4) == 3, m[7:0], m[8]);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
